smpl_queue_seq: RTL

//  Circular sample queue and sequencer that feeds the equalizer's FIR band filters.
//  It stores incoming left/right audio samples into a DEPTH-entry circular buffer.
//  On every new sample, once TAPS samples are held, it streams the newest TAPS-sample

---
 rtl/smpl_queue_seq_if.sv | 24 ++
 rtl/smpl_queue_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/smpl_queue_seq_if.sv
// Sample-path bundle between the codec side and the equalizer band filters.
// master drives new samples in; slave is the queue/sequencer.
interface smpl_queue_seq_if #(
    parameter int DW = 16
);
    logic          wrt_smpl;
    logic [DW-1:0] lft_smpl;
    logic [DW-1:0] rght_smpl;
    logic          sequencing;
    logic [DW-1:0] lft_out;
    logic [DW-1:0] rght_out;
    logic          full;
    logic          ovr;

    modport master (
        output wrt_smpl, lft_smpl, rght_smpl,
        input  sequencing, lft_out, rght_out, full, ovr
    );

    modport slave (
        input  wrt_smpl, lft_smpl, rght_smpl,
        output sequencing, lft_out, rght_out, full, ovr
    );
endinterface

// File: rtl/smpl_queue_seq.sv
// Circular left/right sample queue that, on every new sample once TAPS samples
// are held, streams the newest TAPS-sample window (oldest first) to the FIR band
// filters with sequencing high for exactly TAPS clocks.
module smpl_queue_seq #(
    parameter int DEPTH = 1536,
    parameter int TAPS  = 1021,
    parameter int DW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    smpl_queue_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TAPS + 1);
    localparam int RW = $clog2(TAPS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] new_ptr_reg, new_ptr_next;
    logic [AW-1:0] old_ptr_reg, old_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [RW-1:0] rd_cnt_reg, rd_cnt_next;
    logic          pend_reg, pend_next;
    logic          ovr_reg, ovr_next;
    logic          rd_vld_reg;
    logic          seq_reg;
    logic          rd_en;
    logic          fill_done;
    logic          req;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + AW'(1);
    endfunction

    assign fill_done = (cnt_reg == CW'(TAPS));
    // A readout is owed for the sample that completes the first window and
    // for every sample after that.
    assign req = bus.wrt_smpl && (cnt_reg >= CW'(TAPS - 1));

    // Write pointer, fill count and window start bookkeeping.
    always_comb begin
        new_ptr_next = new_ptr_reg;
        old_ptr_next = old_ptr_reg;
        cnt_next     = cnt_reg;
        if (bus.wrt_smpl) begin
            new_ptr_next = wrap_inc(new_ptr_reg);
            if (fill_done) begin
                old_ptr_next = wrap_inc(old_ptr_reg);
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Readout sequencer: start, stream TAPS reads, drain the last read.
    always_comb begin
        state_next  = state_reg;
        rd_ptr_next = rd_ptr_reg;
        rd_cnt_next = rd_cnt_reg;
        pend_next   = pend_reg;
        ovr_next    = ovr_reg | (req & pend_reg);
        rd_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req || pend_reg) begin
                    // A merged or fresh request always reads the newest window.
                    state_next  = READ;
                    rd_ptr_next = old_ptr_next;
                    rd_cnt_next = '0;
                    pend_next   = 1'b0;
                end
            end
            READ: begin
                rd_en       = 1'b1;
                rd_ptr_next = wrap_inc(rd_ptr_reg);
                rd_cnt_next = rd_cnt_reg + RW'(1);
                if (rd_cnt_reg == RW'(TAPS - 1)) begin
                    state_next = DRAIN;
                end
                if (req) begin
                    pend_next = 1'b1;
                end
            end
            DRAIN: begin
                state_next = IDLE;
                if (req) begin
                    pend_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            new_ptr_reg <= '0;
            old_ptr_reg <= '0;
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
            rd_cnt_reg  <= '0;
            pend_reg    <= 1'b0;
            ovr_reg     <= 1'b0;
            rd_vld_reg  <= 1'b0;
            seq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            new_ptr_reg <= new_ptr_next;
            old_ptr_reg <= old_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            cnt_reg     <= cnt_next;
            rd_cnt_reg  <= rd_cnt_next;
            pend_reg    <= pend_next;
            ovr_reg     <= ovr_next;
            rd_vld_reg  <= rd_en;
            seq_reg     <= rd_vld_reg;
        end
    end

    // One storage bank plus output register per channel (0 = left, 1 = right).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [DW-1:0] mem [DEPTH];
            logic [DW-1:0] wr_data;
            logic [DW-1:0] rd_data;
            logic [DW-1:0] out_reg;

            assign wr_data = (gi == 0) ? bus.lft_smpl : bus.rght_smpl;

            // Sample store with registered read; contents need no reset.
            always_ff @(posedge clk) begin
                if (bus.wrt_smpl) begin
                    mem[new_ptr_reg] <= wr_data;
                end
                if (rd_en) begin
                    rd_data <= mem[rd_ptr_reg];
                end
            end

            // Output register, forced to zero outside a window.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_reg <= '0;
                end else begin
                    out_reg <= rd_vld_reg ? rd_data : '0;
                end
            end
        end
    endgenerate

    assign bus.lft_out    = g_chan[0].out_reg;
    assign bus.rght_out   = g_chan[1].out_reg;
    assign bus.sequencing = seq_reg;
    assign bus.full       = fill_done;
    assign bus.ovr        = ovr_reg;
endmodule
